apb_cmd_requester: RTL and testbench
====================================

APB_CMD_REQUESTER -- requirements
Module: apb_cmd_requester

Interface
REQ-001 Parameter ADDR_W, default 11, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width; strobe width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 cmd_strb  input  DATA_W/8  write byte strobes.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_rdata  output  DATA_W  read data; 0 for writes and for errors.
REQ-015 rsp_err  output  1  pslverr or timeout.
REQ-016 paddr, pwrite, psel, penable, pstrb, pwdata  output  ADDR_W/1/1/1/DATA_W/8/DATA_W  APB requester signals.
REQ-017 prdata, pready, pslverr  input  DATA_W/1/1  APB completer signals.

Function
REQ-018 FSM states are IDLE, SETUP, ACCESS and RESP, with one transaction outstanding at a time.
REQ-019 cmd_ready SHALL be 1 only in IDLE, combinationally from state, and independent of cmd_valid.
REQ-020 On acceptance, paddr, pwrite, pwdata and pstrb are registered and the FSM moves to SETUP; pstrb is forced to 0 for reads.
REQ-021 SETUP lasts exactly one cycle with psel=1 and penable=0, then moves to ACCESS.
REQ-022 ACCESS drives psel=1 and penable=1 and holds all APB outputs stable until exit.
REQ-023 In ACCESS, with pready=1 at a rising edge: capture pslverr into rsp_err and capture prdata into rsp_rdata (read without error, otherwise 0); move to RESP.
REQ-024 In ACCESS, with TIMEOUT_CYCLES>0 and pready still low after TIMEOUT_CYCLES ACCESS cycles: move to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 The timeout counter clears on SETUP entry, increments once per ACCESS cycle, and saturates; a pready arriving in the same cycle as the timeout takes priority over the timeout.
REQ-026 psel and penable SHALL be 0 in IDLE and RESP.
REQ-027 paddr, pwrite, pwdata and pstrb hold their last values outside a transfer.
REQ-028 RESP asserts rsp_valid, holding rsp_rdata and rsp_err stable until rsp_ready; then the FSM moves to IDLE.
REQ-029 Minimum command-to-response latency is 3 cycles: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
REQ-030 Minimum issue interval is 4 cycles per command.

Reset
REQ-031 While rst_n=0: state=IDLE; all outputs 0 except cmd_ready=1; timeout counter 0.
REQ-032 Reset mid-transfer SHALL drop psel and penable immediately (asynchronously) and discard the pending response.

Structure
REQ-033 Package apb_req_pkg SHALL hold the state enum and the default width and timeout localparams.
REQ-034 No sub-module; the FSM, timeout counter and capture registers live in one module.

Verification
REQ-035 Write 0x0A4/0xDEADBEEF/strb 0xF, pready=1 immediately -> psel cycles 1-2, penable cycle 2 only, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
REQ-036 Read 0x010, pready after 3 wait states with prdata=0x12345678 -> APB outputs stable for 4 ACCESS cycles, pstrb=0, rsp_rdata=0x12345678.
REQ-037 Read with pready=1 and pslverr=1 -> rsp_err=1, rsp_rdata=0.
REQ-038 pready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then psel=0 and rsp_err=1; pready on cycle 16 -> normal completion.
REQ-039 rsp_ready held low for 5 cycles with cmd_valid=1 -> cmd_ready=0 and rsp stable throughout; next SETUP 1 cycle after rsp_ready.
REQ-040 rst_n pulsed low during ACCESS -> psel=0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_req_pkg.sv
// Shared definitions for the APB command requester.
//   - default address/data widths and access timeout
//   - FSM state encoding
package apb_req_pkg;

    localparam int unsigned DEF_ADDR_W         = 11;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_cmd_requester.sv
// APB requester: turns one valid/ready command into an APB SETUP/ACCESS
// transfer and returns the result on a valid/ready response channel.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only in IDLE)
//   cmd_write/addr/wdata/strb          command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata, rsp_err                 read data (0 on write/error), error flag
//   paddr/pwrite/psel/penable/pstrb/pwdata   APB requester outputs
//   prdata/pready/pslverr              APB completer inputs
module apb_cmd_requester
    import apb_req_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Counter value seen during the final permitted ACCESS cycle
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   tcnt_q;
    logic               timeout_hit;
    logic               load_cmd;
    logic               psel_d;
    logic               penable_d;
    logic               rsp_valid_d;
    logic               rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_d;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; pready wins over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid)             state_d = ST_SETUP;
            ST_SETUP:                             state_d = ST_ACCESS;
            ST_ACCESS: if (pready || timeout_hit) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready)             state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs
    always_comb begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        load_cmd    = 1'b0;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;

        case (state_d)
            ST_SETUP:  psel_d = 1'b1;
            ST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_RESP:   rsp_valid_d = 1'b1;
            default:   ;
        endcase

        if ((state_q == ST_IDLE) && cmd_valid) begin
            load_cmd = 1'b1;
        end

        if (state_q == ST_ACCESS) begin
            if (pready) begin
                rsp_err_d   = pslverr;
                rsp_rdata_d = (!pwrite && !pslverr) ? prdata : '0;
            end else if (timeout_hit) begin
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
        end
    end

    // Output registers; APB payload only changes on command acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            psel      <= psel_d;
            penable   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            if (load_cmd) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : STRB_W'(0);
            end
        end
    end

    // ACCESS cycle counter: cleared on SETUP entry, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if (load_cmd) begin
            tcnt_q <= '0;
        end else if ((state_q == ST_ACCESS) && (tcnt_q != CNT_MAX)) begin
            tcnt_q <= tcnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Self-checking bench for apb_cmd_requester: directed protocol cases, then
// randomized commands against a completer model and a response scoreboard.
module tb_apb_cmd_requester;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned TMO    = 16;
    localparam int          NCMD   = 60;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [STRB_W-1:0] cmd_strb = '0;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // Manual drive during directed tests, model drive during random phase
    bit                auto_en = 1'b0;
    logic              pready_man = 1'b0, pslverr_man = 1'b0, rsp_ready_man = 1'b0;
    logic [DATA_W-1:0] prdata_man = '0;
    logic              pready_auto = 1'b0, pslverr_auto = 1'b0, rsp_ready_auto = 1'b0;
    logic [DATA_W-1:0] prdata_auto = '0;

    assign pready    = auto_en ? pready_auto    : pready_man;
    assign pslverr   = auto_en ? pslverr_auto   : pslverr_man;
    assign prdata    = auto_en ? prdata_auto    : prdata_man;
    assign rsp_ready = auto_en ? rsp_ready_auto : rsp_ready_man;

    always #5 clk = ~clk;

    apb_cmd_requester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        int                waits;   // ACCESS cycles before pready (0 = immediate)
        logic              err;
        logic [DATA_W-1:0] rdata;
    } xact_t;

    typedef struct {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    xact_t cmd_q[$];
    rsp_t  exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: response and ACCESS length from the command's completer behaviour
    function automatic rsp_t model_rsp(input xact_t t);
        rsp_t r;
        if (t.waits >= int'(TMO)) begin
            r.err   = 1'b1;
            r.rdata = '0;
        end else begin
            r.err   = t.err;
            r.rdata = (!t.write && !t.err) ? t.rdata : '0;
        end
        return r;
    endfunction

    function automatic int model_cycles(input xact_t t);
        return (t.waits < int'(TMO)) ? t.waits + 1 : int'(TMO);
    endfunction

    // Completer model: checks APB payload and ACCESS length, drives pready
    xact_t cur;
    int    acc_cnt = 0;
    bit    in_xfer = 1'b0;

    task automatic check_payload(input string tag);
        check({tag, "_paddr"},  64'(paddr),  64'(cur.addr));
        check({tag, "_pwrite"}, 64'(pwrite), 64'(cur.write));
        check({tag, "_pwdata"}, 64'(pwdata), 64'(cur.wdata));
        check({tag, "_pstrb"},  64'(pstrb),  cur.write ? 64'(cur.strb) : 64'd0);
    endtask

    always @(negedge clk) begin
        if (auto_en) begin
            if (in_xfer && !psel) begin
                check("access_cycles", 64'(acc_cnt), 64'(model_cycles(cur)));
                in_xfer = 1'b0;
            end
            if (psel && !penable) begin
                if (cmd_q.size() == 0) begin
                    flag("setup_without_command");
                end else begin
                    cur     = cmd_q.pop_front();
                    in_xfer = 1'b1;
                    acc_cnt = 0;
                    check_payload("setup");
                end
                pready_auto = 1'b0;
            end else if (psel && penable) begin
                check_payload("access");
                if (acc_cnt >= int'(TMO)) flag("access_past_timeout");
                pready_auto  = (acc_cnt == cur.waits);
                pslverr_auto = pready_auto ? cur.err   : 1'($urandom);
                prdata_auto  = pready_auto ? cur.rdata : $urandom;
                acc_cnt++;
            end else begin
                pready_auto  = 1'b0;
                pslverr_auto = 1'($urandom);
                prdata_auto  = $urandom;
            end
        end
    end

    // Response monitor / scoreboard
    logic              prev_pending = 1'b0;
    logic [DATA_W-1:0] prev_rdata = '0;
    logic              prev_err = 1'b0;
    rsp_t              exp_r;

    always @(negedge clk) begin
        if (auto_en) begin
            if (prev_pending) begin
                check("rsp_valid_held", 64'(rsp_valid), 64'd1);
                check("rsp_rdata_held", 64'(rsp_rdata), 64'(prev_rdata));
                check("rsp_err_held",   64'(rsp_err),   64'(prev_err));
            end
            if (rsp_valid) begin
                check("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                check("psel_in_resp",      64'(psel),      64'd0);
            end
            rsp_ready_auto = ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready_auto) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_response");
                end else begin
                    exp_r = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_r.rdata));
                    check("rsp_err",   64'(rsp_err),   64'(exp_r.err));
                end
                prev_pending = 1'b0;
            end else begin
                prev_pending = rsp_valid;
                prev_rdata   = rsp_rdata;
                prev_err     = rsp_err;
            end
        end
    end

    xact_t t;
    int    bound;
    bit    abort = 1'b0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_psel",      64'(psel),      64'd0);
        check("rst_penable",   64'(penable),   64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_paddr",     64'(paddr),     64'd0);
        check("rst_pwdata",    64'(pwdata),    64'd0);
        check("rst_pstrb",     64'(pstrb),     64'd0);
        check("rst_pwrite",    64'(pwrite),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h0A4;
        cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF;
        pready_man = 1'b1; pslverr_man = 1'b0; prdata_man = 32'hCAFEF00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wr_c1_psel",    64'(psel),    64'd1);
        check("wr_c1_penable", 64'(penable), 64'd0);
        check("wr_c1_paddr",   64'(paddr),   64'h0A4);
        check("wr_c1_pwdata",  64'(pwdata),  64'hDEADBEEF);
        check("wr_c1_pstrb",   64'(pstrb),   64'hF);
        check("wr_c1_pwrite",  64'(pwrite),  64'd1);
        check("wr_c1_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("wr_c2_psel",    64'(psel),    64'd1);
        check("wr_c2_penable", 64'(penable), 64'd1);
        check("wr_c2_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("wr_c3_psel",    64'(psel),    64'd0);
        check("wr_c3_penable", 64'(penable), 64'd0);
        check("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_c3_rsp_err",   64'(rsp_err),   64'd0);
        check("wr_c3_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rsp_ready_man = 1'b1; pready_man = 1'b0;
        @(negedge clk);
        check("wr_c4_rsp_valid", 64'(rsp_valid), 64'd0);
        check("wr_c4_cmd_ready", 64'(cmd_ready), 64'd1);
        check("wr_c4_paddr_hold", 64'(paddr), 64'h0A4);
        rsp_ready_man = 1'b0;

        // Read with three wait states; strobes must be dropped
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 11'h010;
        cmd_wdata = 32'h55; cmd_strb = 4'hF; prdata_man = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rd_setup_psel",    64'(psel),    64'd1);
        check("rd_setup_penable", 64'(penable), 64'd0);
        check("rd_setup_pstrb",   64'(pstrb),   64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rd_acc_psel",    64'(psel),    64'd1);
            check("rd_acc_penable", 64'(penable), 64'd1);
            check("rd_acc_paddr",   64'(paddr),   64'h010);
            check("rd_acc_pwrite",  64'(pwrite),  64'd0);
            check("rd_acc_pstrb",   64'(pstrb),   64'd0);
            check("rd_acc_pwdata",  64'(pwdata),  64'h55);
            if (k == 3) begin
                pready_man = 1'b1; prdata_man = 32'h12345678;
            end
        end
        @(negedge clk);
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        check("rd_rsp_err",   64'(rsp_err),   64'd0);

        // Back-pressured response with a waiting command (next one errors)
        prdata_man = 32'hAAAA5555; pslverr_man = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 11'h3FF; cmd_strb = 4'h3;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
            check("bp_rsp_err",   64'(rsp_err),   64'd0);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_psel",      64'(psel),      64'd0);
            @(negedge clk);
        end
        rsp_ready_man = 1'b1;
        @(negedge clk);
        rsp_ready_man = 1'b0;
        check("bp_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("bp_idle_rsp_valid", 64'(rsp_valid), 64'd0);
        check("bp_idle_psel",      64'(psel),      64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_next_setup_psel",    64'(psel),    64'd1);
        check("bp_next_setup_penable", 64'(penable), 64'd0);
        check("bp_next_setup_paddr",   64'(paddr),   64'h3FF);
        @(negedge clk);
        check("err_acc_penable", 64'(penable), 64'd1);
        @(negedge clk);
        check("err_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_rsp_err",   64'(rsp_err),   64'd1);
        check("err_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rsp_ready_man = 1'b1; pready_man = 1'b0; pslverr_man = 1'b0;
        @(negedge clk);
        rsp_ready_man = 1'b0;

        // Reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h123;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_penable_before", 64'(penable), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_psel",      64'(psel),      64'd0);
        check("rst_mid_penable",   64'(penable),   64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_mid_paddr",     64'(paddr),     64'd0);
        @(negedge clk);
        rst_n = 1'b1; pready_man = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_after_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_after_cmd_ready", 64'(cmd_ready), 64'd1);
            check("rst_after_psel",      64'(psel),      64'd0);
        end
        pready_man = 1'b0;

        // Randomized traffic against the completer model and scoreboard
        auto_en = 1'b1;
        for (int i = 0; i < NCMD && !abort; i++) begin
            t.write = 1'($urandom);
            t.addr  = ADDR_W'($urandom);
            t.wdata = $urandom;
            t.strb  = STRB_W'($urandom);
            t.err   = ($urandom_range(0, 4) == 0);
            t.rdata = $urandom;
            if (i == 0)                          t.waits = 15;
            else if (i == 1)                     t.waits = 16;
            else if (i == 2)                     t.waits = 24;
            else if ($urandom_range(0, 5) == 0)  t.waits = $urandom_range(10, 20);
            else                                 t.waits = $urandom_range(0, 3);

            repeat ($urandom_range(0, 2)) @(negedge clk);
            cmd_valid = 1'b1;
            cmd_write = t.write; cmd_addr = t.addr; cmd_wdata = t.wdata; cmd_strb = t.strb;
            cmd_q.push_back(t);
            exp_q.push_back(model_rsp(t));
            bound = 0;
            while (!cmd_ready && bound < 200) begin
                @(negedge clk);
                bound++;
            end
            if (!cmd_ready) begin
                flag("cmd_accept_timeout");
                abort = 1'b1;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
        end

        bound = 0;
        while (exp_q.size() != 0 && bound < 2000) begin
            @(negedge clk);
            bound++;
        end
        if (exp_q.size() != 0) flag("responses_outstanding");
        repeat (3) @(negedge clk);
        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        flag("global_time_limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
